// File: rtl/cpu2r6.sv
// cpu2r6 - small multi-cycle 32-bit RISC core.
//   16 x 32-bit registers, fixed 32-bit instructions, one instruction in
//   flight. Instruction fetch and load/store use a 512-bit line bus; IN/OUT
//   use a separate 32-bit IO bus.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   busEnRead/busEnWrite     grants for the line bus strobes
//   busRead/busWrite         one-cycle line read / line write strobes
//   busAddr                  byte address, [5:2] selects the word in the line
//   busRdy/busInput          read completion and read line
//   busOutput                write line
//   ioBusAddr/Size/Out/Wr/Rd IO request, one-cycle strobes
//   ioBusIn/ioBusRdy         IO read data and completion
//   dummy                    current FSM state code

module cpu2r6_ram (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  logic [31:0] regs [0:15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (we && waddr != 4'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 4'd0) ? 32'h0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 4'd0) ? 32'h0 : regs[raddr_b];
endmodule

// Register file wrapper: two read ports, one write port, r0 hardwired to 0.
module cpu2r6_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  cpu2r6_ram ram0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b)
  );
endmodule

module cpu2r6 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         busEnRead,
  input  logic         busEnWrite,
  input  logic         busRdy,
  output logic         busRead,
  output logic         busWrite,
  output logic [31:0]  busAddr,
  input  logic [511:0] busInput,
  output logic [511:0] busOutput,
  output logic [31:0]  ioBusAddr,
  output logic [1:0]   ioBusSize,
  output logic [31:0]  ioBusOut,
  input  logic [31:0]  ioBusIn,
  input  logic         ioBusRdy,
  output logic         ioBusWr,
  output logic         ioBusRd,
  output logic [3:0]   dummy
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_FWAIT  = 4'd1,
    S_EXEC   = 4'd2,
    S_MREQ   = 4'd3,
    S_MWAIT  = 4'd4,
    S_MWR    = 4'd5,
    S_IOWAIT = 4'd6
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2,
                         OP_OR  = 4'h3, OP_XOR = 4'h4, OP_SHL = 4'h5,
                         OP_SHR = 4'h6, OP_ADDI = 4'h7, OP_LUI = 4'h8,
                         OP_LW  = 4'h9, OP_SW  = 4'hA, OP_BEQ = 4'hB,
                         OP_BNE = 4'hC, OP_JAL = 4'hD, OP_IN  = 4'hE,
                         OP_OUT = 4'hF;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    ir_q, ir_d;
  logic           bus_read_q, bus_read_d;
  logic           bus_write_q, bus_write_d;
  logic [31:0]    bus_addr_q, bus_addr_d;
  logic [511:0]   bus_output_q, bus_output_d;
  logic [31:0]    io_addr_q, io_addr_d;
  logic [1:0]     io_size_q, io_size_d;
  logic [31:0]    io_out_q, io_out_d;
  logic           io_wr_q, io_wr_d;
  logic           io_rd_q, io_rd_d;

  logic [3:0]  op, rd, rs, rt;
  logic [15:0] imm;
  logic [31:0] simm;
  logic [31:0] rs_val, rb_val, eff_addr, alu_res, pc_inc;
  logic [3:0]  raddr_b;
  logic        rf_we;
  logic [31:0] rf_wdata;

  assign op   = ir_q[31:28];
  assign rd   = ir_q[27:24];
  assign rs   = ir_q[23:20];
  assign rt   = ir_q[19:16];
  assign imm  = ir_q[15:0];
  assign simm = {{16{imm[15]}}, imm};

  // Port B reads rt for register-register ALU ops, otherwise rd (store
  // data, branch compare, OUT data).
  assign raddr_b  = (op <= OP_SHR) ? rt : rd;
  assign eff_addr = rs_val + simm;
  assign pc_inc   = pc_q + 32'd4;

  cpu2r6_regfile regf0 (
    .clk(clk), .rst(rst), .we(rf_we), .waddr(rd), .wdata(rf_wdata),
    .raddr_a(rs), .raddr_b(raddr_b), .rdata_a(rs_val), .rdata_b(rb_val)
  );

  always_comb begin
    alu_res = 32'h0;
    case (op)
      OP_ADD:  alu_res = rs_val + rb_val;
      OP_SUB:  alu_res = rs_val - rb_val;
      OP_AND:  alu_res = rs_val & rb_val;
      OP_OR:   alu_res = rs_val | rb_val;
      OP_XOR:  alu_res = rs_val ^ rb_val;
      OP_SHL:  alu_res = rs_val << rb_val[4:0];
      OP_SHR:  alu_res = rs_val >> rb_val[4:0];
      OP_ADDI: alu_res = eff_addr;
      OP_LUI:  alu_res = {imm, 16'h0};
      default: alu_res = 32'h0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    bus_read_d   = 1'b0;
    bus_write_d  = 1'b0;
    bus_addr_d   = bus_addr_q;
    bus_output_d = bus_output_q;
    io_addr_d    = io_addr_q;
    io_size_d    = io_size_q;
    io_out_d     = io_out_q;
    io_wr_d      = 1'b0;
    io_rd_d      = 1'b0;
    rf_we        = 1'b0;
    rf_wdata     = alu_res;
    case (state_q)
      S_FETCH: if (busEnRead) begin
        bus_read_d = 1'b1;
        bus_addr_d = pc_q;
        state_d    = S_FWAIT;
      end
      S_FWAIT: if (busRdy) begin
        ir_d    = busInput[{pc_q[5:2], 5'b0} +: 32];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_LW, OP_SW: begin
            pc_d    = pc_q;
            state_d = S_MREQ;
          end
          OP_BEQ: if (rb_val == rs_val) pc_d = pc_inc + (simm << 2);
          OP_BNE: if (rb_val != rs_val) pc_d = pc_inc + (simm << 2);
          OP_JAL: begin
            rf_we    = 1'b1;
            rf_wdata = pc_inc;
            pc_d     = eff_addr;
          end
          OP_IN: begin
            pc_d      = pc_q;
            io_rd_d   = 1'b1;
            io_addr_d = eff_addr;
            io_size_d = 2'd2;
            state_d   = S_IOWAIT;
          end
          OP_OUT: begin
            pc_d      = pc_q;
            io_wr_d   = 1'b1;
            io_addr_d = eff_addr;
            io_out_d  = rb_val;
            io_size_d = rt[1:0];
            state_d   = S_IOWAIT;
          end
          default: rf_we = 1'b1;
        endcase
      end
      S_MREQ: if (busEnRead) begin
        bus_read_d = 1'b1;
        bus_addr_d = eff_addr;
        state_d    = S_MWAIT;
      end
      S_MWAIT: if (busRdy) begin
        if (op == OP_LW) begin
          rf_we    = 1'b1;
          rf_wdata = busInput[{bus_addr_q[5:2], 5'b0} +: 32];
          pc_d     = pc_inc;
          state_d  = S_FETCH;
        end else begin
          // Read-modify-write of the whole line: only the addressed word
          // changes, the rest is written back as read.
          bus_output_d = busInput;
          bus_output_d[{bus_addr_q[5:2], 5'b0} +: 32] = rb_val;
          state_d = S_MWR;
        end
      end
      S_MWR: if (busEnWrite) begin
        bus_write_d = 1'b1;
        pc_d        = pc_inc;
        state_d     = S_FETCH;
      end
      S_IOWAIT: if (ioBusRdy) begin
        if (op == OP_IN) begin
          rf_we    = 1'b1;
          rf_wdata = ioBusIn;
        end
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      bus_read_q   <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_addr_q   <= '0;
      bus_output_q <= '0;
      io_addr_q    <= '0;
      io_size_q    <= 2'd2;
      io_out_q     <= '0;
      io_wr_q      <= 1'b0;
      io_rd_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      bus_read_q   <= bus_read_d;
      bus_write_q  <= bus_write_d;
      bus_addr_q   <= bus_addr_d;
      bus_output_q <= bus_output_d;
      io_addr_q    <= io_addr_d;
      io_size_q    <= io_size_d;
      io_out_q     <= io_out_d;
      io_wr_q      <= io_wr_d;
      io_rd_q      <= io_rd_d;
    end
  end

  assign busRead   = bus_read_q;
  assign busWrite  = bus_write_q;
  assign busAddr   = bus_addr_q;
  assign busOutput = bus_output_q;
  assign ioBusAddr = io_addr_q;
  assign ioBusSize = io_size_q;
  assign ioBusOut  = io_out_q;
  assign ioBusWr   = io_wr_q;
  assign ioBusRd   = io_rd_q;
  assign dummy     = state_q;
endmodule

// File: tb/tb_cpu2r6.sv
// Directed bench for cpu2r6: a 1 KB line memory answers reads combinationally
// (busRdy in the same cycle busRead is seen) and absorbs line writes.
module tb_cpu2r6;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         busEnRead = 1'b1, busEnWrite = 1'b1, busRdy;
  logic         busRead, busWrite;
  logic [31:0]  busAddr;
  logic [511:0] busInput, busOutput;
  logic [31:0]  ioBusAddr, ioBusOut;
  logic [1:0]   ioBusSize;
  logic [31:0]  ioBusIn = 32'h1234_5678;
  logic         ioBusRdy = 1'b0;
  logic         ioBusWr, ioBusRd;
  logic [3:0]   dummy;

  logic [31:0]  mem [0:255];
  logic         auto_rdy = 1'b1;
  int n_cmp = 0, n_err = 0;
  int rd_cnt, wr_cnt, iow_cnt, ior_cnt, addr8_cnt;
  logic [31:0]  last_wr_addr;
  logic [511:0] last_wr_line;

  always #5 clk = ~clk;

  cpu2r6 dut (
    .clk(clk), .rst(rst), .busEnRead(busEnRead), .busEnWrite(busEnWrite),
    .busRdy(busRdy), .busRead(busRead), .busWrite(busWrite), .busAddr(busAddr),
    .busInput(busInput), .busOutput(busOutput), .ioBusAddr(ioBusAddr),
    .ioBusSize(ioBusSize), .ioBusOut(ioBusOut), .ioBusIn(ioBusIn),
    .ioBusRdy(ioBusRdy), .ioBusWr(ioBusWr), .ioBusRd(ioBusRd), .dummy(dummy)
  );

  assign busRdy = busRead & auto_rdy;

  always_comb begin
    busInput = '0;
    for (int k = 0; k < 16; k++)
      busInput[32*k +: 32] = mem[int'(busAddr[9:6]) * 16 + k];
  end

  // One clock: sample 1 time unit after the rising edge, count strobes and
  // commit any line write into the memory model.
  task automatic tick();
    @(posedge clk); #1;
    if (busRead) begin
      rd_cnt++;
      if (busAddr == 32'h8) addr8_cnt++;
    end
    if (ioBusWr) iow_cnt++;
    if (ioBusRd) ior_cnt++;
    if (busWrite) begin
      wr_cnt++;
      last_wr_addr = busAddr;
      last_wr_line = busOutput;
      for (int k = 0; k < 16; k++)
        mem[int'(busAddr[9:6]) * 16 + k] = busOutput[32*k +: 32];
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'hB000_FFFF; // BEQ r0,r0,self
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rd_cnt = 0; wr_cnt = 0; iow_cnt = 0; ior_cnt = 0; addr8_cnt = 0;
    last_wr_addr = '0; last_wr_line = '0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(2);
    if (busRead !== 1'b0 || busWrite !== 1'b0 || ioBusWr !== 1'b0 || ioBusRd !== 1'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b%b%b%b want 0000", busRead, busWrite, ioBusWr, ioBusRd);
    end
    n_cmp++;
    if (busAddr !== 32'h0 || ioBusAddr !== 32'h0 || ioBusOut !== 32'h0 || busOutput !== '0) begin
      n_err++; $display("FAIL reset_addr_data: busAddr %h ioBusAddr %h ioBusOut %h", busAddr, ioBusAddr, ioBusOut);
    end
    n_cmp++;
    if (ioBusSize !== 2'd2) begin n_err++; $display("FAIL reset_iosize: got %0d want 2", ioBusSize); end
    n_cmp++;
    if (dummy !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dummy); end
    n_cmp++;
    if (dut.pc_q !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", dut.pc_q); end
    n_cmp++;
  endtask

  task automatic test_addi();
    clear_mem();
    mem[0] = 32'h7200_0005;
    do_reset();
    tick();
    if (busRead !== 1'b1 || busAddr !== 32'h0) begin
      n_err++; $display("FAIL addi_fetch0: busRead %b busAddr %h want 1 00000000", busRead, busAddr);
    end
    n_cmp++;
    ticks(2);
    if (dut.regf0.ram0.regs[2] !== 32'd5) begin
      n_err++; $display("FAIL addi_r2: got %h want 5", dut.regf0.ram0.regs[2]);
    end
    n_cmp++;
    if (dummy !== 4'd0) begin n_err++; $display("FAIL addi_state: got %0d want 0", dummy); end
    n_cmp++;
    tick();
    if (busRead !== 1'b1 || busAddr !== 32'h4) begin
      n_err++; $display("FAIL addi_fetch4: busRead %b busAddr %h want 1 00000004", busRead, busAddr);
    end
    n_cmp++;
  endtask

  task automatic test_out();
    clear_mem();
    mem[0] = 32'h7200_0005;
    mem[1] = 32'hF202_0010;
    ioBusRdy = 1'b0;
    do_reset();
    ticks(12);
    if (iow_cnt !== 1 || ior_cnt !== 0) begin
      n_err++; $display("FAIL out_strobes: wr %0d rd %0d want 1 0", iow_cnt, ior_cnt);
    end
    n_cmp++;
    if (ioBusAddr !== 32'h10 || ioBusOut !== 32'd5 || ioBusSize !== 2'd2) begin
      n_err++; $display("FAIL out_payload: addr %h data %h size %0d want 10 5 2", ioBusAddr, ioBusOut, ioBusSize);
    end
    n_cmp++;
    if (dummy !== 4'd6) begin n_err++; $display("FAIL out_iowait: got %0d want 6", dummy); end
    n_cmp++;
    ioBusRdy = 1'b1;
    tick();
    ioBusRdy = 1'b0;
    if (dummy !== 4'd0 || dut.pc_q !== 32'h8) begin
      n_err++; $display("FAIL out_done: state %0d pc %h want 0 8", dummy, dut.pc_q);
    end
    n_cmp++;
  endtask

  task automatic test_sw_lw();
    clear_mem();
    for (int k = 0; k < 16; k++) mem[64 + k] = 32'h1000 + k;
    mem[0] = 32'h7200_0005;
    mem[1] = 32'hA200_0104;
    mem[2] = 32'h9300_0104;
    do_reset();
    ticks(40);
    if (wr_cnt !== 1 || last_wr_addr !== 32'h104) begin
      n_err++; $display("FAIL sw_write: count %0d addr %h want 1 104", wr_cnt, last_wr_addr);
    end
    n_cmp++;
    if (last_wr_line[63:32] !== 32'd5) begin
      n_err++; $display("FAIL sw_word1: got %h want 5", last_wr_line[63:32]);
    end
    n_cmp++;
    if (last_wr_line[31:0] !== 32'h1000 || last_wr_line[511:480] !== 32'h100F) begin
      n_err++; $display("FAIL sw_preserve: w0 %h w15 %h want 1000 100f", last_wr_line[31:0], last_wr_line[511:480]);
    end
    n_cmp++;
    if (dut.regf0.ram0.regs[3] !== 32'd5) begin
      n_err++; $display("FAIL lw_r3: got %h want 5", dut.regf0.ram0.regs[3]);
    end
    n_cmp++;
  endtask

  task automatic test_loop();
    clear_mem();
    mem[0] = 32'h7200_0003;
    mem[1] = 32'h7220_FFFF;
    mem[2] = 32'hC200_FFFE;
    mem[3] = 32'h7400_0001;
    do_reset();
    ticks(60);
    if (addr8_cnt !== 3) begin n_err++; $display("FAIL loop_bne_fetches: got %0d want 3", addr8_cnt); end
    n_cmp++;
    if (dut.regf0.ram0.regs[2] !== 32'h0) begin
      n_err++; $display("FAIL loop_r2: got %h want 0", dut.regf0.ram0.regs[2]);
    end
    n_cmp++;
    if (dut.regf0.ram0.regs[4] !== 32'h1) begin
      n_err++; $display("FAIL loop_fallthrough: r4 %h want 1", dut.regf0.ram0.regs[4]);
    end
    n_cmp++;
  endtask

  task automatic test_hold_and_reset();
    clear_mem();
    mem[0] = 32'h7200_0005;
    mem[1] = 32'h9300_0104;
    busEnRead = 1'b0;
    do_reset();
    ticks(10);
    if (rd_cnt !== 0 || dummy !== 4'd0) begin
      n_err++; $display("FAIL hold_no_read: reads %0d state %0d want 0 0", rd_cnt, dummy);
    end
    n_cmp++;
    busEnRead = 1'b1;
    ticks(6);
    auto_rdy = 1'b0;
    tick();
    if (dummy !== 4'd4 || busRead !== 1'b1 || busAddr !== 32'h104 || dut.pc_q !== 32'h4) begin
      n_err++; $display("FAIL mwait_entry: state %0d rd %b addr %h pc %h want 4 1 104 4", dummy, busRead, busAddr, dut.pc_q);
    end
    n_cmp++;
    rst = 1'b1;
    #1;
    if (busRead !== 1'b0 || dummy !== 4'd0 || dut.pc_q !== 32'h0 || busAddr !== 32'h0) begin
      n_err++; $display("FAIL async_reset: rd %b state %0d pc %h addr %h want 0 0 0 0", busRead, dummy, dut.pc_q, busAddr);
    end
    n_cmp++;
    if (dut.regf0.ram0.regs[2] !== 32'h0) begin
      n_err++; $display("FAIL reset_regs: r2 %h want 0", dut.regf0.ram0.regs[2]);
    end
    n_cmp++;
    auto_rdy = 1'b1;
    do_reset();
    ticks(3);
    if (dut.regf0.ram0.regs[2] !== 32'd5) begin
      n_err++; $display("FAIL restart_r2: got %h want 5", dut.regf0.ram0.regs[2]);
    end
    n_cmp++;
  endtask

  task automatic test_r0_wrap();
    clear_mem();
    mem[0] = 32'h7000_0007; // ADDI r0,r0,7
    mem[1] = 32'h7100_FFFF; // ADDI r1,r0,-1
    mem[2] = 32'h7200_0001; // ADDI r2,r0,1
    mem[3] = 32'h0312_0000; // ADD  r3,r1,r2
    mem[4] = 32'h8500_ABCD; // LUI  r5,0xABCD
    mem[5] = 32'h6652_0000; // SHR  r6,r5,r2
    do_reset();
    ticks(30);
    if (dut.regf0.ram0.regs[0] !== 32'h0) begin
      n_err++; $display("FAIL r0_zero: got %h want 0", dut.regf0.ram0.regs[0]);
    end
    n_cmp++;
    if (dut.regf0.ram0.regs[1] !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL addi_neg: got %h want ffffffff", dut.regf0.ram0.regs[1]);
    end
    n_cmp++;
    if (dut.regf0.ram0.regs[3] !== 32'h0) begin
      n_err++; $display("FAIL add_wrap: got %h want 0", dut.regf0.ram0.regs[3]);
    end
    n_cmp++;
    if (dut.regf0.ram0.regs[5] !== 32'hABCD_0000) begin
      n_err++; $display("FAIL lui: got %h want abcd0000", dut.regf0.ram0.regs[5]);
    end
    n_cmp++;
    if (dut.regf0.ram0.regs[6] !== 32'h55E6_8000) begin
      n_err++; $display("FAIL shr: got %h want 55e68000", dut.regf0.ram0.regs[6]);
    end
    n_cmp++;
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_addi();
    test_out();
    test_sw_lw();
    test_loop();
    test_hold_and_reset();
    test_r0_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
